// File: rtl/ttt_pkg.sv
// Shared types, board codes and cell addressing for the tic-tac-toe match controller.
package ttt_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        WAIT,
        ISSUE,
        SETTLE,
        CHECK,
        OVER
    } state_e;

    localparam logic [1:0] ST_PLAY   = 2'b00;
    localparam logic [1:0] ST_FIRST  = 2'b01;
    localparam logic [1:0] ST_SECOND = 2'b10;
    localparam logic [1:0] ST_DRAW   = 2'b11;

    localparam int unsigned COORD_W  = 2;
    localparam int unsigned NCELL    = 9;
    localparam int unsigned CELL_W   = 4;
    localparam int unsigned IDX_SPAN = 16;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } move_t;

    // Flat board index for 1-based coordinates: (row-1)*3 + (col-1).
    function automatic logic [CELL_W-1:0] cell_index(input logic [COORD_W-1:0] row,
                                                     input logic [COORD_W-1:0] col);
        logic [CELL_W-1:0] r0;
        logic [CELL_W-1:0] c0;
        r0 = CELL_W'(row) - CELL_W'(1);
        c0 = CELL_W'(col) - CELL_W'(1);
        return CELL_W'(r0 * CELL_W'(3)) + c0;
    endfunction

endpackage

// File: rtl/ttt_move_check.sv
// Combinational legality check of a requested move against board occupancy.
module ttt_move_check
    import ttt_pkg::*;
(
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    input  logic [NCELL-1:0]   i_valid,
    output logic               o_legal_c
);

    logic [IDX_SPAN-1:0] w_valid_ext;
    logic [CELL_W-1:0]   w_idx;

    // Widened so any 4-bit index (including out-of-range ones from row/col 0) is in range.
    assign w_valid_ext = IDX_SPAN'(i_valid);
    assign w_idx       = cell_index(i_row, i_col);
    assign o_legal_c   = (i_row != '0) && (i_col != '0) && !w_valid_ext[w_idx];

endmodule

// File: rtl/ttt_match_ctrl.sv
// Match controller: turn order, move validation, board strobes and win/draw tallies.
// Optional per-turn forfeit timer is built when TURN_TIMEOUT_EN is defined.
module ttt_match_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic [1:0]         req,
    input  logic [3:0]         req_row,
    input  logic [3:0]         req_col,
    output logic [1:0]         ack,
    output logic               reject,
    output logic               brd_reset,
    output logic               brd_set,
    output logic [1:0]         brd_row,
    output logic [1:0]         brd_col,
    input  logic [8:0]         brd_valid,
    input  logic [1:0]         brd_state,
    output logic               turn,
    output logic               first,
    output logic               game_over,
    output logic [SCORE_W-1:0] wins0,
    output logic [SCORE_W-1:0] wins1,
`ifdef TURN_TIMEOUT_EN
    output logic [SCORE_W-1:0] draws,
    output logic               timeout
`else
    output logic [SCORE_W-1:0] draws
`endif
);

    localparam int unsigned CNT_MAX_A = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
    localparam int unsigned CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_cnt_clr;
    logic               r_turn;
    logic               r_first;
    logic               w_turn_nxt;
    logic               w_first_nxt;
    logic [1:0]         r_ack;
    logic [1:0]         w_ack_nxt;
    logic               r_reject;
    logic               w_reject_nxt;
    logic               r_brd_reset;
    logic               r_brd_set;
    logic               r_game_over;
    move_t              r_move;
    move_t              w_move;
    logic               w_load;
    logic               w_legal;
    logic               w_settle_done;
    logic               w_hold_done;
    logic               w_win0_inc;
    logic               w_win1_inc;
    logic               w_draw_inc;
    logic [SCORE_W-1:0] r_wins0;
    logic [SCORE_W-1:0] r_wins1;
    logic [SCORE_W-1:0] r_draws;
`ifdef TURN_TIMEOUT_EN
    logic               r_timeout;
    logic               w_timeout_nxt;
`endif

    // Only the awaited player's coordinates are ever examined.
    assign w_move.row = r_turn ? req_row[3:2] : req_row[1:0];
    assign w_move.col = r_turn ? req_col[3:2] : req_col[1:0];

    ttt_move_check u_move_check (
        .i_row     (w_move.row),
        .i_col     (w_move.col),
        .i_valid   (brd_valid),
        .o_legal_c (w_legal)
    );

    assign w_settle_done = (SETTLE_CYC <= 1) || (r_cnt == CNT_W'(SETTLE_CYC - 1));
    assign w_hold_done   = (HOLD_CYC != 0) && (r_cnt == CNT_W'(HOLD_CYC - 1));

    // Next-state, turn bookkeeping and tally/ack requests.
    always_comb begin
        w_state_nxt  = r_state;
        w_turn_nxt   = r_turn;
        w_first_nxt  = r_first;
        w_ack_nxt    = 2'b00;
        w_reject_nxt = 1'b0;
        w_load       = 1'b0;
        w_win0_inc   = 1'b0;
        w_win1_inc   = 1'b0;
        w_draw_inc   = 1'b0;
`ifdef TURN_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
`endif
        if (new_game && (r_state != CLEAR)) begin
            w_state_nxt = CLEAR;
            w_first_nxt = ~r_first;
            w_turn_nxt  = ~r_first;
        end else begin
            case (r_state)
                CLEAR: w_state_nxt = WAIT;
                WAIT: begin
                    // r_ack gate: the requester still holds req in the cycle its ack is visible.
                    if (req[r_turn] && (r_ack == 2'b00)) begin
                        w_ack_nxt = r_turn ? 2'b10 : 2'b01;
                        if (w_legal) begin
                            w_load      = 1'b1;
                            w_state_nxt = ISSUE;
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        w_timeout_nxt = 1'b1;
                        w_win0_inc    = r_turn;
                        w_win1_inc    = ~r_turn;
                        w_state_nxt   = OVER;
                    end
`endif
                end
                ISSUE: w_state_nxt = SETTLE;
                SETTLE: begin
                    if (w_settle_done) begin
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    case (brd_state)
                        ST_PLAY: begin
                            w_turn_nxt  = ~r_turn;
                            w_state_nxt = WAIT;
                        end
                        ST_FIRST: begin
                            w_win0_inc  = ~r_first;
                            w_win1_inc  = r_first;
                            w_state_nxt = OVER;
                        end
                        ST_SECOND: begin
                            w_win0_inc  = r_first;
                            w_win1_inc  = ~r_first;
                            w_state_nxt = OVER;
                        end
                        ST_DRAW: begin
                            w_draw_inc  = 1'b1;
                            w_state_nxt = OVER;
                        end
                    endcase
                end
                OVER: begin
                    if (w_hold_done) begin
                        w_state_nxt = CLEAR;
                        w_first_nxt = ~r_first;
                        w_turn_nxt  = ~r_first;
                    end
                end
                default: w_state_nxt = CLEAR;
            endcase
        end
    end

    assign w_cnt_clr = (w_state_nxt != r_state) || (w_ack_nxt != 2'b00);

    // State register plus registered strobes, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_cnt       <= '0;
            r_turn      <= 1'b0;
            r_first     <= 1'b0;
            r_ack       <= 2'b00;
            r_reject    <= 1'b0;
            r_brd_reset <= 1'b1;
            r_brd_set   <= 1'b0;
            r_game_over <= 1'b0;
            r_move      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            r_turn      <= w_turn_nxt;
            r_first     <= w_first_nxt;
            r_ack       <= w_ack_nxt;
            r_reject    <= w_reject_nxt;
            r_brd_reset <= (w_state_nxt == CLEAR);
            r_brd_set   <= (w_state_nxt == ISSUE);
            r_game_over <= (w_state_nxt == OVER);
            if (w_load) begin
                r_move <= w_move;
            end
        end
    end

    // Saturating tallies, preserved across games.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wins0 <= '0;
            r_wins1 <= '0;
            r_draws <= '0;
        end else begin
            if (w_win0_inc && (r_wins0 != '1)) begin
                r_wins0 <= r_wins0 + SCORE_W'(1);
            end
            if (w_win1_inc && (r_wins1 != '1)) begin
                r_wins1 <= r_wins1 + SCORE_W'(1);
            end
            if (w_draw_inc && (r_draws != '1)) begin
                r_draws <= r_draws + SCORE_W'(1);
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`endif

    assign ack       = r_ack;
    assign reject    = r_reject;
    assign brd_reset = r_brd_reset;
    assign brd_set   = r_brd_set;
    assign brd_row   = r_move.row;
    assign brd_col   = r_move.col;
    assign turn      = r_turn;
    assign first     = r_first;
    assign game_over = r_game_over;
    assign wins0     = r_wins0;
    assign wins1     = r_wins1;
    assign draws     = r_draws;

endmodule

// File: tb/tb_ttt_match_ctrl.sv
// Self-checking bench for ttt_match_ctrl with a behavioural 3x3 board and match model.
module tb_ttt_match_ctrl;

    localparam int unsigned SCORE_W     = 8;
    localparam int unsigned SETTLE_CYC  = 2;
    localparam int unsigned HOLD_CYC    = 16;
    localparam int unsigned TIMEOUT_CYC = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               new_game;
    logic [1:0]         req;
    logic [3:0]         req_row;
    logic [3:0]         req_col;
    logic [1:0]         ack;
    logic               reject;
    logic               brd_reset;
    logic               brd_set;
    logic [1:0]         brd_row;
    logic [1:0]         brd_col;
    logic [8:0]         brd_valid;
    logic [1:0]         brd_state;
    logic               turn;
    logic               first;
    logic               game_over;
    logic [SCORE_W-1:0] wins0;
    logic [SCORE_W-1:0] wins1;
    logic [SCORE_W-1:0] draws;
`ifdef TURN_TIMEOUT_EN
    logic               timeout;
`endif

    int total = 0;
    int bad   = 0;

    // Board model: 0 empty, 1 first mover's mark, 2 second mover's mark.
    int owner [9];
    int mcount = 0;

    int overlap  = 0;
    int set_cnt  = 0;
    int rst_cnt  = 0;
    int ack1_cnt = 0;

    int e_wins [2];
    int e_draws = 0;
    int e_first = 0;
    int e_turn  = 0;
    int e_sets  = 0;
    bit over    = 1'b0;

    always #5 clk = ~clk;

    ttt_match_ctrl #(
        .SCORE_W     (SCORE_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .new_game  (new_game),
        .req       (req),
        .req_row   (req_row),
        .req_col   (req_col),
        .ack       (ack),
        .reject    (reject),
        .brd_reset (brd_reset),
        .brd_set   (brd_set),
        .brd_row   (brd_row),
        .brd_col   (brd_col),
        .brd_valid (brd_valid),
        .brd_state (brd_state),
        .turn      (turn),
        .first     (first),
        .game_over (game_over),
        .wins0     (wins0),
        .wins1     (wins1),
`ifdef TURN_TIMEOUT_EN
        .draws     (draws),
        .timeout   (timeout)
`else
        .draws     (draws)
`endif
    );

    function automatic logic [1:0] board_result(input int o [9]);
        int lines [8][3];
        int filled;
        lines = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                  '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int l = 0; l < 8; l++) begin
            if (o[lines[l][0]] != 0 && o[lines[l][0]] == o[lines[l][1]] &&
                o[lines[l][1]] == o[lines[l][2]]) begin
                return (o[lines[l][0]] == 1) ? 2'b01 : 2'b10;
            end
        end
        filled = 0;
        for (int i = 0; i < 9; i++) begin
            if (o[i] != 0) filled++;
        end
        return (filled == 9) ? 2'b11 : 2'b00;
    endfunction

    always @(posedge clk) begin
        if (brd_reset === 1'b1) begin
            for (int i = 0; i < 9; i++) owner[i] <= 0;
            mcount <= 0;
        end else if (brd_set === 1'b1) begin
            if (brd_row != 2'd0 && brd_col != 2'd0)
                owner[(int'(brd_row) - 1) * 3 + int'(brd_col) - 1] <= (mcount % 2 == 0) ? 1 : 2;
            mcount <= mcount + 1;
        end
    end

    always_comb begin
        brd_state = board_result(owner);
        for (int i = 0; i < 9; i++) brd_valid[i] = (owner[i] != 0);
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (brd_set === 1'b1 && brd_reset === 1'b1) overlap++;
            if (ack === 2'b11) overlap++;
            if (brd_set === 1'b1) set_cnt++;
            if (brd_reset === 1'b1) rst_cnt++;
            if (ack[1] === 1'b1) ack1_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tallies(input string tag);
        chk({tag, "_wins0"}, 32'(wins0), e_wins[0]);
        chk({tag, "_wins1"}, 32'(wins1), e_wins[1]);
        chk({tag, "_draws"}, 32'(draws), e_draws);
    endtask

    // Present a request for player p and wait (bounded) for its ack.
    task automatic issue_req(input int p, input int r, input int c, output bit legal);
        int k;
        legal = 1'b0;
        if (r != 0 && c != 0) legal = (owner[(r - 1) * 3 + (c - 1)] == 0);
        chk("turn_before_req", turn, p);
        req_row[2*p +: 2] = 2'(r);
        req_col[2*p +: 2] = 2'(c);
        req[p] = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (ack[p] !== 1'b1 && k < 20);
        chk("ack_seen", ack[p], 1);
        chk("reject", reject, legal ? 0 : 1);
        req[p] = 1'b0;
        if (legal) e_sets++;
    endtask

    // Called at the ack cycle of a legal move; follows it to the CHECK outcome.
    task automatic settle_check(input int p);
        logic [1:0] res;
        repeat (SETTLE_CYC + 2) tick();
        res = board_result(owner);
        if (res == 2'b00) begin
            e_turn = 1 - p;
            chk("turn_toggle", turn, e_turn);
            chk("playing_not_over", game_over, 0);
        end else begin
            if (res == 2'b01) e_wins[e_first]++;
            else if (res == 2'b10) e_wins[1 - e_first]++;
            else e_draws++;
            over = 1'b1;
            chk("game_over", game_over, 1);
            chk_tallies("result");
        end
    endtask

    task automatic move(input int p, input int r, input int c);
        bit legal;
        issue_req(p, r, c, legal);
        if (legal) begin
            settle_check(p);
        end else begin
            tick();
            chk("turn_kept", turn, p);
            chk("no_ack_after_reject", ack, 0);
        end
    endtask

    task automatic hold_end();
        int k;
        int r0;
        r0 = rst_cnt;
        k = 0;
        for (int n = 0; n < int'(HOLD_CYC) + 8 && brd_reset !== 1'b1; n++) begin
            if (game_over === 1'b1) k++;
            tick();
        end
        chk("hold_len", k, HOLD_CYC);
        chk("clear_strobe", brd_reset, 1);
        chk("clear_not_over", game_over, 0);
        e_first = 1 - e_first;
        chk("first_toggle_hold", first, e_first);
        tick();
        chk("clear_once", rst_cnt - r0, 1);
        chk("wait_no_clear", brd_reset, 0);
        chk("turn_new_game", turn, e_first);
        chk_tallies("hold");
        e_turn = e_first;
        over = 1'b0;
    endtask

    task automatic newgame_end();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ng_clear", brd_reset, 1);
        e_first = 1 - e_first;
        chk("ng_first", first, e_first);
        chk_tallies("ng");
        tick();
        chk("ng_wait", brd_reset, 0);
        chk("ng_turn", turn, e_first);
        e_turn = e_first;
        over = 1'b0;
    endtask

    int dr_r [9] = '{1, 1, 1, 2, 2, 2, 3, 3, 3};
    int dr_c [9] = '{1, 2, 3, 2, 1, 3, 2, 1, 3};

    initial begin
        bit legal;
        int k;
        int a1;
        int s0;
        int tries;

        for (int i = 0; i < 9; i++) owner[i] = 0;
        e_wins[0] = 0;
        e_wins[1] = 0;
        reset    = 1'b1;
        new_game = 1'b1;
        req      = 2'b00;
        req_row  = 4'd0;
        req_col  = 4'd0;
        repeat (3) tick();
        chk("rst_brd_reset", brd_reset, 1);
        chk("rst_brd_set", brd_set, 0);
        chk("rst_ack", ack, 0);
        chk("rst_reject", reject, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_first", first, 0);
        chk("rst_turn", turn, 0);
        chk_tallies("rst");
        reset    = 1'b0;
        new_game = 1'b0;
        tick();
        chk("post_rst_wait", brd_reset, 0);

        // Game 1: p0 takes the top row.
        move(0, 1, 1);
        move(1, 2, 1);
        move(0, 1, 2);
        move(1, 2, 2);
        move(0, 1, 3);
        chk("g1_over", over, 1);
        hold_end();
        chk("g2_first", first, 1);

        // Game 2: occupied cell rejected while p1 holds an early request.
        move(1, 2, 2);
        req_row[3:2] = 2'd3;
        req_col[3:2] = 2'd3;
        req[1] = 1'b1;
        a1 = ack1_cnt;
        s0 = set_cnt;
        move(0, 2, 2);
        chk("no_set_on_reject", set_cnt - s0, 0);
        chk("held_req_ignored", ack1_cnt - a1, 0);
        issue_req(0, 1, 1, legal);
        settle_check(0);
        k = 0;
        do begin
            tick();
            k++;
        end while (ack[1] !== 1'b1 && k < 20);
        chk("held_ack_latency", SETTLE_CYC + 2 + k, SETTLE_CYC + 3);
        chk("held_reject", reject, 0);
        req[1] = 1'b0;
        e_sets++;
        settle_check(1);

        // new_game during SETTLE with a request presented alongside.
        issue_req(0, 1, 2, legal);
        tick();
        new_game = 1'b1;
        req_row[1:0] = 2'd1;
        req_col[1:0] = 2'd3;
        req[0] = 1'b1;
        tick();
        new_game = 1'b0;
        req[0] = 1'b0;
        chk("settle_ng_clear", brd_reset, 1);
        chk("settle_ng_no_ack", ack, 0);
        e_first = 1 - e_first;
        chk("settle_ng_first", first, e_first);
        chk_tallies("settle_ng");
        tick();
        chk("settle_ng_wait_ack", ack, 0);
        chk("settle_ng_turn", turn, e_first);
        e_turn = e_first;

        // new_game in WAIT with a simultaneous legal request: request dropped.
        s0 = set_cnt;
        req_row[2*e_turn +: 2] = 2'd1;
        req_col[2*e_turn +: 2] = 2'd1;
        req[e_turn] = 1'b1;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        req = 2'b00;
        chk("wait_ng_clear", brd_reset, 1);
        chk("wait_ng_no_ack", ack, 0);
        tick();
        chk("wait_ng_no_ack2", ack, 0);
        e_first = 1 - e_first;
        chk("wait_ng_first", first, e_first);
        chk("wait_ng_no_set", set_cnt - s0, 0);
        e_turn = e_first;

        // Full nine-move draw.
        for (int i = 0; i < 9; i++) move(e_turn, dr_r[i], dr_c[i]);
        chk("draw_over", over, 1);
        chk("draw_count", 32'(draws), 1);
        hold_end();

        // Random games, illegal moves mixed in.
        for (int g = 0; g < 6; g++) begin
            tries = 0;
            while (!over && tries < 60) begin
                move(e_turn,
                     ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)),
                     int'($urandom_range(1, 3)));
                tries++;
            end
            if (over && $urandom_range(0, 1) == 1) hold_end();
            else newgame_end();
        end

`ifdef TURN_TIMEOUT_EN
        // Player 1 idles until forfeit.
        if (e_first == 0) move(0, 2, 2);
        k = 0;
        do begin
            tick();
            k++;
        end while (timeout !== 1'b1 && k < 40);
        chk("timeout_latency", k, TIMEOUT_CYC);
        e_wins[0]++;
        chk("timeout_over", game_over, 1);
        chk_tallies("timeout");
        tick();
        chk("timeout_pulse", timeout, 0);
        newgame_end();
`endif

        repeat (3) tick();
        chk("strobe_overlap", overlap, 0);
        chk("set_pulses", set_cnt, e_sets);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
